sled7_scan: RTL
===============

Name: sled7_scan

Overview:
Multiplexed N-digit hexadecimal 7-segment display driver. It generalises the single-digit combinational hex decoder into a time-multiplexed scanner with a prescaler, a digit-select counter and double-buffered value loading (tear-free), plus per-digit blanking and a frame strobe. It sits between the CPU output/bus register and the board's common-cathode/anode display bank.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, CLK50M cycles per digit slot (>=2); 50000 gives 1 kHz per digit
DIG_ACTIVE_LOW, 0, 1 means DIG outputs are driven active-low; SEG is always active-high

Ports:
CLK50M  in  1  system clock
RST_N  in  1  asynchronous active-low reset
VALUE  in  4*DIGITS  hex value; digit i = VALUE[4i+3:4i], digit 0 = least significant
LOAD  in  1  capture VALUE into the pending buffer this cycle
BLANK_MASK  in  DIGITS  bit i=1 blanks digit i (sampled live)
SEG  out  7  {a,b,c,d,e,f,g}, a = MSB, active-high
DIG  out  DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW)
FRAME  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Interface fixed: single clock CLK50M; RST_N is asynchronous, active-low.
- Reset: presc=0, idx=0, pending=0, pend_flag=0, display=0, SEG=7'b0000000, DIG all inactive, FRAME=0.
- Prescaler presc counts 0..SCAN_DIV-1 and wraps; tick = (presc==SCAN_DIV-1).
- On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1. On tick with idx==DIGITS-1 (frame wrap): FRAME=1 next cycle, else FRAME=0.
- LOAD=1: pending <= VALUE, pend_flag <= 1. Repeated LOADs within a frame: last one wins.
- On frame wrap: if LOAD=1 in that same cycle, display <= VALUE; else if pend_flag, display <= pending; pend_flag <= 0. Display never changes mid-frame.
- Decode table (hex -> abcdefg): 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1110011, A 1110111, b 0011111, c 0001101, d 0111101, E 1001111, F 1000111. Full case; no latches.
- Outputs registered, one-cycle latency from (presc, idx):
  - presc==0 (first cycle of each slot, ghosting dead-time): SEG=0, DIG all inactive.
  - otherwise: if BLANK_MASK[idx] (or suppressed, see below): SEG=0, DIG inactive; else DIG one-hot bit idx active, SEG=decode(display nibble idx).
- DIGITS=1: idx stays 0; every tick is a frame wrap.
- RST_N asserted mid-frame: all state cleared immediately; pending LOAD is discarded.

Optional Feature:
Macro SLED7_LZS_EN. Defined: leading-zero suppression. Digits above the most-significant non-zero nibble of display are treated as blanked (SEG=0, DIG inactive). Digit 0 is always shown, so 0x0000 displays "0". Suppression is ORed with BLANK_MASK. Undefined: all digits are shown, including leading zeros, and the logic is absent.

Test Plan:
(Bench: DIGITS=4, SCAN_DIV=4, DIG_ACTIVE_LOW=0.)
- Reset release: RST_N low for 3 cycles -> SEG=0, DIG=0000, FRAME=0 throughout. First FRAME pulse 16 cycles after release.
- LOAD VALUE=16'h12AF once mid-frame -> display unchanged until the next FRAME. Next frame slots show DIG=0001/SEG=1000111 (F), 0010/1110111 (A), 0100/1101101 (2), 1000/0110000 (1). Each slot's first cycle is blanked.
- LOAD 16'h1111 then 16'h2222 in the same frame -> only 2222 is displayed after the wrap. LOAD asserted exactly on the wrap cycle with 16'h3333 -> 3333 is shown in the very next frame.
- BLANK_MASK=4'b0100 with display 16'h8888 -> slot 2 has DIG=0000 and SEG=0; other slots show SEG=1111111.
- SLED7_LZS_EN defined, display 16'h0050 -> digits 3 and 2 blanked, digit 1 shows 1011011, digit 0 shows 1111110. Display 16'h0000 -> only digit 0 is lit, showing "0".
- Assert RST_N low while idx=2 and a pending LOAD exists -> outputs clear asynchronously. After release, display=0 and the pending value is never shown.

Source files
------------

// File: rtl/sled7_scan_if.sv
// Display-driver bus: value/load/blank from the CPU side, SEG/DIG/FRAME to the panel.
interface sled7_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] VALUE;
  logic                LOAD;
  logic [DIGITS-1:0]   BLANK_MASK;
  logic [6:0]          SEG;
  logic [DIGITS-1:0]   DIG;
  logic                FRAME;

  modport master (output VALUE, LOAD, BLANK_MASK, input SEG, DIG, FRAME);
  modport slave  (input VALUE, LOAD, BLANK_MASK, output SEG, DIG, FRAME);
endinterface

// File: rtl/sled7_scan.sv
// Multiplexed N-digit hex 7-segment scanner with tear-free double-buffered loads.
// Optional leading-zero suppression when SLED7_LZS_EN is defined.
module sled7_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b0000000;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1110011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b0001101;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
    endcase
  end
endmodule

module sled7_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input logic         CLK50M,
  input logic         RST_N,
  sled7_scan_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]             presc;
  logic [IW-1:0]             idx;
  logic [4*DIGITS-1:0]       pending, display;
  logic                      pend_flag;
  logic [6:0]                seg_q;
  logic [DIGITS-1:0]         dig_q;
  logic                      frame_q;
  logic                      tick, wrap;
  logic [DIGITS-1:0][6:0]    seg_all;
  logic [DIGITS-1:0]         hide, dig_on;

  assign tick   = (presc == PRESC_MAX);
  assign wrap   = tick && (idx == IDX_MAX);
  assign dig_on = DIGITS'(1) << idx;

  // Scan timebase: prescaler and digit select
  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end
  end

  // Display only changes on the frame wrap so a frame never mixes two values
  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      pending   <= '0;
      pend_flag <= 1'b0;
      display   <= '0;
    end else begin
      if (bus.LOAD) begin
        pending   <= bus.VALUE;
        pend_flag <= 1'b1;
      end
      if (wrap) begin
        pend_flag <= 1'b0;
        if (bus.LOAD)      display <= bus.VALUE;
        else if (pend_flag) display <= pending;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    sled7_dec u_dec (.nib(display[4*g +: 4]), .seg(seg_all[g]));
  end

`ifdef SLED7_LZS_EN
  // A digit is suppressed when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    logic seen;
    seen = 1'b0;
    hide = bus.BLANK_MASK;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen    = seen | (display[4*i +: 4] != 4'h0);
      hide[i] = bus.BLANK_MASK[i] | ~seen;
    end
  end
`else
  assign hide = bus.BLANK_MASK;
`endif

  // First cycle of each slot is dead-time against ghosting between digits
  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      seg_q   <= 7'b0000000;
      dig_q   <= DIG_OFF;
      frame_q <= 1'b0;
    end else begin
      frame_q <= wrap;
      if (presc == '0 || hide[idx]) begin
        seg_q <= 7'b0000000;
        dig_q <= DIG_OFF;
      end else begin
        seg_q <= seg_all[idx];
        dig_q <= dig_on ^ DIG_OFF;
      end
    end
  end

  assign bus.SEG   = seg_q;
  assign bus.DIG   = dig_q;
  assign bus.FRAME = frame_q;
endmodule
